// File: rtl/ysyx_23060236_ifu.sv
// Instruction fetch stage: one-outstanding fetch on a valid/ready memory port,
// registered handoff to the IDU, redirect on jump_wrong with stale-response discard.
module ysyx_23060236_ifu #(
  parameter logic [31:0] RESET_PC = 32'h3000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        jump_wrong,
  input  logic [31:0] jump_target,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic [31:0] in,
  output logic [31:0] pc,
  output logic        idu_valid,
  input  logic        idu_ready
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_fetch_q, pc_fetch_d;
  logic [XLEN-1:0]   in_q, in_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              idu_valid_q, idu_valid_d;
  logic              mem_req_valid_q, mem_req_valid_d;
  logic              discard_q, discard_d;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      pc_fetch_q      <= RESET_PC;
      in_q            <= '0;
      pc_q            <= '0;
      idu_valid_q     <= 1'b0;
      mem_req_valid_q <= 1'b0;
      discard_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      pc_fetch_q      <= pc_fetch_d;
      in_q            <= in_d;
      pc_q            <= pc_d;
      idu_valid_q     <= idu_valid_d;
      mem_req_valid_q <= mem_req_valid_d;
      discard_q       <= discard_d;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    pc_fetch_d = pc_fetch_q;
    in_d       = in_q;
    pc_d       = pc_q;
    discard_d  = discard_q;

    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (mem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (mem_resp_valid) begin
          if (discard_q) begin
            discard_d = 1'b0;
            state_d   = REQ;
          end else begin
            in_d    = mem_resp_data;
            pc_d    = pc_fetch_q;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (idu_ready) begin
          pc_fetch_d = pc_fetch_q + XLEN'(4);
          state_d    = REQ;
        end
      end
    endcase

    // Redirect overrides everything; an in-flight request must have its response dropped
    if (jump_wrong) begin
      pc_fetch_d = jump_target & ~XLEN'(3);
      in_d       = in_q;
      pc_d       = pc_q;
      unique case (state_q)
        WAIT: begin
          if (mem_resp_valid) begin
            discard_d = 1'b0;
            state_d   = REQ;
          end else begin
            discard_d = 1'b1;
            state_d   = WAIT;
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            discard_d = 1'b1;
            state_d   = WAIT;
          end else begin
            state_d = REQ;
          end
        end
        default: state_d = REQ;
      endcase
    end

    idu_valid_d     = (state_d == HOLD);
    mem_req_valid_d = (state_d == REQ);
  end

  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_addr  = pc_fetch_q;
  assign in            = in_q;
  assign pc            = pc_q;
  assign idu_valid     = idu_valid_q;

endmodule

// File: tb/tb_ysyx_23060236_ifu.sv
// Bench for ysyx_23060236_ifu: directed redirect/reset scenarios then random
// traffic, every cycle compared against a transaction-level fetch model.
module tb_ysyx_23060236_ifu;

  localparam logic [31:0] RESET_PC = 32'h3000_0000;

  logic        clock;
  logic        reset;
  logic        jump_wrong;
  logic [31:0] jump_target;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic [31:0] in;
  logic [31:0] pc;
  logic        idu_valid;
  logic        idu_ready;

  ysyx_23060236_ifu #(.RESET_PC(RESET_PC)) dut (
    .clock(clock), .reset(reset),
    .jump_wrong(jump_wrong), .jump_target(jump_target),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .in(in), .pc(pc), .idu_valid(idu_valid), .idu_ready(idu_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: what the fetch unit has promised to the outside world
  logic        m_started;   // first clock after reset seen
  logic        m_req;       // a request is being offered
  logic        m_wait;      // a request is outstanding
  logic        m_stale;     // the outstanding response belongs to a squashed path
  logic        m_vld;       // an instruction is being offered to the IDU
  logic [31:0] m_fetch, m_in, m_pc;

  // Memory model
  logic        mem_pend;
  int          mem_cnt;
  logic [31:0] mem_word;
  int          dly_lo = 0, dly_hi = 0;
  logic        use_fix = 1'b0;
  logic [31:0] fix_word = '0;
  logic        inj_resp = 1'b0;

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_started = 1'b0; m_req = 1'b0; m_wait = 1'b0; m_stale = 1'b0; m_vld = 1'b0;
    m_fetch = RESET_PC; m_in = '0; m_pc = '0;
    mem_pend = 1'b0; mem_cnt = 0; mem_word = '0;
  endtask

  task automatic check_outputs();
    check32("req_valid", 32'(mem_req_valid), 32'(m_req));
    check32("req_addr", mem_req_addr, m_fetch);
    check32("idu_valid", 32'(idu_valid), 32'(m_vld));
    check32("in", in, m_in);
    check32("pc", pc, m_pc);
  endtask

  // One clock: check, drive at negedge, advance model at posedge
  task automatic step(input logic rdy, input logic irdy, input logic jw, input logic [31:0] jt);
    logic fire, resp;
    check_outputs();
    mem_req_ready  = rdy;
    idu_ready      = irdy;
    jump_wrong     = jw;
    jump_target    = jt;
    mem_resp_valid = inj_resp | (mem_pend && mem_cnt == 0);
    mem_resp_data  = (mem_pend && mem_cnt == 0) ? mem_word : $urandom;
    @(posedge clock);
    fire = m_req & rdy;
    resp = mem_resp_valid;
    if (!m_started) begin
      m_started = 1'b1;
      m_req = 1'b1;
      if (jw) m_fetch = jt & 32'hFFFF_FFFC;
    end else if (jw) begin
      m_fetch = jt & 32'hFFFF_FFFC;
      m_vld = 1'b0;
      if (m_wait && !resp) m_stale = 1'b1;
      else if (fire) begin m_wait = 1'b1; m_stale = 1'b1; m_req = 1'b0; end
      else begin m_wait = 1'b0; m_stale = 1'b0; m_req = 1'b1; end
    end else begin
      if (fire) begin
        m_req = 1'b0; m_wait = 1'b1;
      end else if (m_wait && resp) begin
        m_wait = 1'b0;
        if (m_stale) begin m_stale = 1'b0; m_req = 1'b1; end
        else begin m_vld = 1'b1; m_in = mem_resp_data; m_pc = m_fetch; end
      end else if (m_vld && irdy) begin
        m_vld = 1'b0; m_fetch = m_fetch + 32'd4; m_req = 1'b1;
      end
    end
    if (mem_pend && mem_cnt == 0) mem_pend = 1'b0;
    else if (mem_pend) mem_cnt--;
    if (fire) begin
      mem_pend = 1'b1;
      mem_cnt  = $urandom_range(dly_hi, dly_lo);
      mem_word = use_fix ? fix_word : $urandom;
    end
    @(negedge clock);
  endtask

  // Asynchronous reset in mid-cycle, with junk responses during reset and in IDLE
  task automatic do_reset();
    #2 reset = 1'b0;
    #1 model_reset();
    check_outputs();
    mem_resp_valid = 1'b1;
    mem_resp_data  = $urandom;
    @(posedge clock);
    @(negedge clock);
    check_outputs();
    reset = 1'b1;
    inj_resp = 1'b1;
    step(1'b0, 1'b0, 1'b0, '0);
    inj_resp = 1'b0;
  endtask

  initial begin
    reset = 1'b0; jump_wrong = 1'b0; jump_target = '0; mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0; mem_resp_data = '0; idu_ready = 1'b0;
    model_reset();
    @(negedge clock);
    check_outputs();
    reset = 1'b1;

    // First fetch after reset release
    use_fix = 1'b1; fix_word = 32'h0000_0013;
    step(1'b1, 1'b0, 1'b0, '0);
    check32("t1_req_valid", 32'(mem_req_valid), 32'd1);
    check32("t1_addr", mem_req_addr, 32'h3000_0000);
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);
    check32("t1_idu_valid", 32'(idu_valid), 32'd1);
    check32("t1_in", in, 32'h0000_0013);
    check32("t1_pc", pc, 32'h3000_0000);
    use_fix = 1'b0;

    // IDU stall then accept
    repeat (5) step(1'b1, 1'b0, 1'b0, '0);
    check32("t2_in_held", in, 32'h0000_0013);
    check32("t2_no_req", 32'(mem_req_valid), 32'd0);
    step(1'b0, 1'b1, 1'b0, '0);
    check32("t2_next_addr", mem_req_addr, 32'h3000_0004);

    // Redirect while waiting, response arrives two cycles later and is dropped
    dly_lo = 2; dly_hi = 2;
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b1, 32'h3000_0100);
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);
    check32("t3_idu_valid", 32'(idu_valid), 32'd0);
    check32("t3_req_valid", 32'(mem_req_valid), 32'd1);
    check32("t3_addr", mem_req_addr, 32'h3000_0100);

    // Redirect coinciding with the response
    dly_lo = 0; dly_hi = 0;
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b1, 32'h3000_0200);
    check32("t4_addr", mem_req_addr, 32'h3000_0200);
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);
    check32("t4_accept", 32'(idu_valid), 32'd1);
    check32("t4_pc", pc, 32'h3000_0200);

    // Redirect on the accepting cycle of a request
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b1, 1'b0, 1'b1, 32'h3000_0300);
    step(1'b0, 1'b0, 1'b0, '0);
    check32("t5_dropped", 32'(idu_valid), 32'd0);
    check32("t5_addr", mem_req_addr, 32'h3000_0300);

    // PC wrap, then reset while waiting
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    check32("t6_aligned", mem_req_addr, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);
    check32("t6_pc", pc, 32'hFFFF_FFFC);
    step(1'b0, 1'b1, 1'b0, '0);
    check32("t6_wrap", mem_req_addr, 32'h0000_0000);
    dly_lo = 3; dly_hi = 3;
    step(1'b1, 1'b0, 1'b0, '0);
    do_reset();
    check32("t6_refetch", mem_req_addr, RESET_PC);
    check32("t6_refetch_v", 32'(mem_req_valid), 32'd1);

    // Random traffic
    dly_lo = 0; dly_hi = 3;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      else step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 50,
                $urandom_range(0, 99) < 8, $urandom);
    end
    check_outputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
